rl_sector_framer: RTL and testbench
===================================

# rl_sector_framer

Bit-level framer between the data separator and `headerDecode`/data path: hunts the all-zeros preamble and sync bit of each RL02 sector and drives the shared `decode_state` bus. It forwards exactly 48 header bits as `headerBitIn`/`headerBitInStrobe`, skips the header-to-data gap, and hunts the data preamble and sync. It then assembles the data field into 16-bit words, with the data CRC delivered as the final word.

## Interface
- `PREAMBLE_MIN`, 32: minimum consecutive zeros before a sync `1` is accepted.
- `GAP_BITS`, 64: bit cells ignored after the header field before the data preamble hunt.
- `SYNC_TIMEOUT`, 256: bit cells allowed in the data preamble hunt before abandoning the sector.
- `DATA_WORDS`, 128: data words per sector, excluding CRC.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  drive ready and heads on track; low forces IDLE.
- `bitIn`  in  1  decoded bit from the separator.
- `bitInStrobe`  in  1  one-cycle pulse marking `bitIn` valid. Pulses are at least 4 clocks apart.
- `decode_state`  out  3  framer state, with encodings from `FSMStates.v`: DSFM_IDLE=000, DSFM_HPRE=001, DSFM_HDR=010, DSFM_GAP=011, DSFM_DPRE=100, DSFM_DATA=101.
- `headerBitIn`  out  1  forwarded header bit.
- `headerBitInStrobe`  out  1  forwarded header strobe.
- `dataWord`  out  16  assembled data or CRC word.
- `dataWordStrobe`  out  1  one-cycle pulse when `dataWord`/`dataWordIndex` are valid.
- `dataWordIndex`  out  8  word index: 0..DATA_WORDS-1 for data, DATA_WORDS for CRC.
- `syncLost`  out  1  one-cycle pulse on data-sync timeout or on abort mid-field.

## Operation
- Reset values:
  - Outputs: `decode_state`=IDLE; all other outputs 0.
  - Internal counters: zero count, bit count and word index all 0.
- State register is `decode_state` itself. All transitions happen on a `bitInStrobe` cycle unless stated otherwise.
- IDLE:
  - `enable`=1 → HPRE, with zero count cleared.
- HPRE:
  - bit 0 → zero count +1, saturating at 255.
  - bit 1 with zero count ≥ PREAMBLE_MIN → HDR. The sync bit is not forwarded.
  - bit 1 with zero count < PREAMBLE_MIN → zero count = 0, stay in HPRE.
- HDR:
  - Each strobe is forwarded; bit count +1.
  - On the 48th forwarded bit → GAP, bit count = 0.
- GAP:
  - Count strobes. On the GAP_BITS-th strobe → DPRE, with zero count and hunt count cleared.
- DPRE:
  - Zero/sync rule is the same as HPRE. Sync → DATA, with word index 0 and bit count 0.
  - Each strobe also increments the hunt count.
  - Hunt count reaching SYNC_TIMEOUT without sync → pulse `syncLost`, go to HPRE.
  - If sync and timeout fall on the same strobe, sync wins.
- DATA:
  - Shift bits into a 16-bit word.
    - Data words (index < DATA_WORDS) are LSB-first: `{bit, w[15:1]}`.
    - The CRC word (index = DATA_WORDS) is MSB-first: `{w[14:0], bit}`.
  - Every 16th bit → present the word and pulse `dataWordStrobe`; word index +1 after the pulse.
  - After the CRC word → HPRE, with zero count cleared.
- `enable` low in any state → IDLE on the next clock, with all counters cleared.
  - No further header or data strobes are issued.
  - `syncLost` pulses if the abort happens from HDR, DPRE or DATA.
- `rst` asserted mid-operation → reset values on the next edge. No `syncLost` pulse.
- `bitInStrobe` outside HPRE, HDR, GAP, DPRE and DATA is ignored.

## Timing
- `headerBitIn`/`headerBitInStrobe` are registered copies of `bitIn`/`bitInStrobe`, with 1-clock latency.
- `decode_state` becomes DSFM_HDR on the clock after the sync strobe. The first forwarded header strobe therefore follows at least 4 clocks later. `headerDecode` needs only 1 clock to leave its wait state.
- `decode_state` leaves DSFM_HDR in the same cycle the 48th forwarded strobe is asserted. It never re-enters DSFM_HDR before a new HPRE sync, so the decoder cannot restart mid-sector.
- `dataWordStrobe` is asserted 1 clock after the 16th bit strobe of a word. `dataWord` and `dataWordIndex` are stable while it is high and hold until the next word.
- `syncLost` asserts 1 clock after the timeout strobe or after the `enable` fall.

## Test plan
- Header with long preamble:
  - Stimulus: enable, 40 zeros, `1`, then header bits sector=5, head=1, cyl=0x12A, 16 zeros, CRC=0xBEEF.
  - Required: exactly 48 header strobes with matching bits; `decode_state` sequence 001→010→011.
- Short preamble:
  - Stimulus: 20 zeros, `1`, 40 zeros, `1`.
  - Required: the first `1` is rejected, with state held at 001. The second `1` enters 010.
- Data field:
  - Stimulus: header field complete, 64 gap bits, 32 zeros, `1`, then words 0x1234, 0xA5A5 … with CRC 0x0F0F sent MSB-first.
  - Required: `dataWord`=0x1234 at index 0, 0xA5A5 at index 1, 0x0F0F at index 128; then state returns to 001.
- Data sync timeout:
  - Stimulus: 256 zero strobes in DPRE.
  - Required: one `syncLost` pulse and state 001; no `dataWordStrobe`.
- Abort mid-header:
  - Stimulus: `enable` dropped after 20 forwarded header bits.
  - Required: state 000 the next clock, one `syncLost` pulse, and no further `headerBitInStrobe` despite continued input strobes.
- Reset mid-data:
  - Stimulus: `rst` at data word 50.
  - Required: all outputs 0 and state 000, no `syncLost`; a clean reacquire on the next sector.

Source files
------------

// File: rtl/rl_sector_framer.sv
// RL02 sector framer: hunts header/data preambles, forwards the 48 header bits,
// skips the inter-field gap and assembles the data field (plus CRC) into words.
module rl_sector_framer #(
    parameter int PREAMBLE_MIN = 32,
    parameter int GAP_BITS     = 64,
    parameter int SYNC_TIMEOUT = 256,
    parameter int DATA_WORDS   = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bitIn,
    input  logic        bitInStrobe,
    output logic [2:0]  decode_state,
    output logic        headerBitIn,
    output logic        headerBitInStrobe,
    output logic [15:0] dataWord,
    output logic        dataWordStrobe,
    output logic [7:0]  dataWordIndex,
    output logic        syncLost
);

    typedef enum logic [2:0] {
        DSFM_IDLE = 3'b000,
        DSFM_HPRE = 3'b001,
        DSFM_HDR  = 3'b010,
        DSFM_GAP  = 3'b011,
        DSFM_DPRE = 3'b100,
        DSFM_DATA = 3'b101
    } state_t;

    localparam int                HUNT_W     = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [7:0]        PRE_MIN    = 8'(PREAMBLE_MIN);
    localparam logic [7:0]        HDR_LAST   = 8'd47;
    localparam logic [7:0]        GAP_LAST   = 8'(GAP_BITS - 1);
    localparam logic [7:0]        WORD_LAST  = 8'd15;
    localparam logic [7:0]        CRC_IDX    = 8'(DATA_WORDS);
    localparam logic [HUNT_W-1:0] HUNT_LIMIT = HUNT_W'(SYNC_TIMEOUT);

    state_t             state, state_next;
    logic [7:0]         zero_cnt, zero_next;
    logic [7:0]         bit_cnt, bit_next;
    logic [HUNT_W-1:0]  hunt_cnt, hunt_next;
    logic [7:0]         word_idx, word_idx_next;
    logic [15:0]        shift_word, shift_next;

    logic               header_bit_next, header_strobe_next;
    logic [15:0]        data_word_next;
    logic               data_strobe_next;
    logic [7:0]         data_index_next;
    logic               sync_lost_next;

    logic [7:0]         zero_inc;
    logic [HUNT_W-1:0]  hunt_inc;
    logic               sync_ok;
    logic [15:0]        word_shifted;

    assign decode_state = state;

    assign zero_inc = (zero_cnt == 8'hFF) ? zero_cnt : zero_cnt + 8'd1;
    assign hunt_inc = hunt_cnt + 1'b1;
    assign sync_ok  = bitIn && (zero_cnt >= PRE_MIN);
    // Data words arrive LSB-first; the trailing CRC word arrives MSB-first.
    assign word_shifted = (word_idx == CRC_IDX) ? {shift_word[14:0], bitIn}
                                                : {bitIn, shift_word[15:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= DSFM_IDLE;
            zero_cnt          <= '0;
            bit_cnt           <= '0;
            hunt_cnt          <= '0;
            word_idx          <= '0;
            shift_word        <= '0;
            headerBitIn       <= 1'b0;
            headerBitInStrobe <= 1'b0;
            dataWord          <= '0;
            dataWordStrobe    <= 1'b0;
            dataWordIndex     <= '0;
            syncLost          <= 1'b0;
        end else begin
            state             <= state_next;
            zero_cnt          <= zero_next;
            bit_cnt           <= bit_next;
            hunt_cnt          <= hunt_next;
            word_idx          <= word_idx_next;
            shift_word        <= shift_next;
            headerBitIn       <= header_bit_next;
            headerBitInStrobe <= header_strobe_next;
            dataWord          <= data_word_next;
            dataWordStrobe    <= data_strobe_next;
            dataWordIndex     <= data_index_next;
            syncLost          <= sync_lost_next;
        end
    end

    always_comb begin
        state_next         = state;
        zero_next          = zero_cnt;
        bit_next           = bit_cnt;
        hunt_next          = hunt_cnt;
        word_idx_next      = word_idx;
        shift_next         = shift_word;
        header_bit_next    = headerBitIn;
        header_strobe_next = 1'b0;
        data_word_next     = dataWord;
        data_strobe_next   = 1'b0;
        data_index_next    = dataWordIndex;
        sync_lost_next     = 1'b0;

        if (!enable) begin
            // Losing the drive mid-field is reported so the host can retry.
            state_next     = DSFM_IDLE;
            zero_next      = '0;
            bit_next       = '0;
            hunt_next      = '0;
            word_idx_next  = '0;
            shift_next     = '0;
            sync_lost_next = (state == DSFM_HDR) || (state == DSFM_DPRE) ||
                             (state == DSFM_DATA);
        end else begin
            case (state)
                DSFM_IDLE: begin
                    state_next = DSFM_HPRE;
                    zero_next  = '0;
                end
                DSFM_HPRE: begin
                    if (bitInStrobe) begin
                        if (!bitIn) begin
                            zero_next = zero_inc;
                        end else if (sync_ok) begin
                            state_next = DSFM_HDR;
                            bit_next   = '0;
                        end else begin
                            zero_next = '0;
                        end
                    end
                end
                DSFM_HDR: begin
                    if (bitInStrobe) begin
                        header_strobe_next = 1'b1;
                        header_bit_next    = bitIn;
                        if (bit_cnt == HDR_LAST) begin
                            state_next = DSFM_GAP;
                            bit_next   = '0;
                        end else begin
                            bit_next = bit_cnt + 8'd1;
                        end
                    end
                end
                DSFM_GAP: begin
                    if (bitInStrobe) begin
                        if (bit_cnt == GAP_LAST) begin
                            state_next = DSFM_DPRE;
                            bit_next   = '0;
                            zero_next  = '0;
                            hunt_next  = '0;
                        end else begin
                            bit_next = bit_cnt + 8'd1;
                        end
                    end
                end
                DSFM_DPRE: begin
                    if (bitInStrobe) begin
                        hunt_next = hunt_inc;
                        // A sync on the final hunt cell still counts.
                        if (sync_ok) begin
                            state_next    = DSFM_DATA;
                            word_idx_next = '0;
                            bit_next      = '0;
                        end else if (hunt_inc == HUNT_LIMIT) begin
                            state_next     = DSFM_HPRE;
                            sync_lost_next = 1'b1;
                            zero_next      = '0;
                            hunt_next      = '0;
                        end else if (!bitIn) begin
                            zero_next = zero_inc;
                        end else begin
                            zero_next = '0;
                        end
                    end
                end
                DSFM_DATA: begin
                    if (bitInStrobe) begin
                        shift_next = word_shifted;
                        if (bit_cnt == WORD_LAST) begin
                            bit_next         = '0;
                            data_word_next   = word_shifted;
                            data_strobe_next = 1'b1;
                            data_index_next  = word_idx;
                            if (word_idx == CRC_IDX) begin
                                state_next    = DSFM_HPRE;
                                zero_next     = '0;
                                word_idx_next = '0;
                            end else begin
                                word_idx_next = word_idx + 8'd1;
                            end
                        end else begin
                            bit_next = bit_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_next = DSFM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rl_sector_framer.sv
// Directed bench for rl_sector_framer: header/data framing, preamble boundaries,
// data-sync timeout, enable abort and synchronous reset mid-data.
module tb_rl_sector_framer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        bitIn;
    logic        bitInStrobe;
    logic [2:0]  decode_state;
    logic        headerBitIn;
    logic        headerBitInStrobe;
    logic [15:0] dataWord;
    logic        dataWordStrobe;
    logic [7:0]  dataWordIndex;
    logic        syncLost;

    int checks   = 0;
    int failures = 0;

    int          hdr_cnt = 0;
    logic        hdr_bits [0:1023];
    logic [2:0]  hdr_last_state = 3'b111;
    int          dstrobe_cnt = 0;
    logic [15:0] words [0:255];
    int          sync_cnt = 0;

    logic        snap_sync;
    logic        snap_dstrobe;
    logic [2:0]  snap_state;
    logic [15:0] snap_word;
    logic [7:0]  snap_index;

    logic [47:0] hdr_vec;

    rl_sector_framer dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .bitIn             (bitIn),
        .bitInStrobe       (bitInStrobe),
        .decode_state      (decode_state),
        .headerBitIn       (headerBitIn),
        .headerBitInStrobe (headerBitInStrobe),
        .dataWord          (dataWord),
        .dataWordStrobe    (dataWordStrobe),
        .dataWordIndex     (dataWordIndex),
        .syncLost          (syncLost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive observers of the output pulses.
    always @(negedge clk) begin
        if (headerBitInStrobe) begin
            if (hdr_cnt < 1024) hdr_bits[hdr_cnt] = headerBitIn;
            hdr_cnt++;
            hdr_last_state = decode_state;
        end
        if (dataWordStrobe) begin
            words[dataWordIndex] = dataWord;
            dstrobe_cnt++;
        end
        if (syncLost) sync_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One bit cell: strobe for one clock, then three idle clocks.
    task automatic apply_stimulus(input logic b);
        bitIn       = b;
        bitInStrobe = 1'b1;
        @(posedge clk); #1;
        bitInStrobe  = 1'b0;
        snap_sync    = syncLost;
        snap_dstrobe = dataWordStrobe;
        snap_state   = decode_state;
        snap_word    = dataWord;
        snap_index   = dataWordIndex;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0);
    endtask

    task automatic send_header(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(hdr_vec[i]);
    endtask

    task automatic send_word_lsb(input logic [15:0] w);
        for (int i = 0; i < 16; i++) apply_stimulus(w[i]);
    endtask

    function automatic logic [15:0] word_val(input int i);
        if (i == 0) return 16'h1234;
        if (i == 1) return 16'hA5A5;
        return 16'(i * 16'h0101);
    endfunction

    initial begin
        int base_h;
        int base_d;
        int base_s;
        int bad;
        logic [15:0] crc;

        hdr_vec     = {16'hBEEF, 16'h0000, 9'h12A, 1'b1, 6'd5};
        rst         = 1'b1;
        enable      = 1'b1;
        bitIn       = 1'b0;
        bitInStrobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", decode_state, 3'b000);
        check_output("reset_hbit", headerBitIn, 1'b0);
        check_output("reset_hstrobe", headerBitInStrobe, 1'b0);
        check_output("reset_word", dataWord, 16'h0000);
        check_output("reset_dstrobe", dataWordStrobe, 1'b0);
        check_output("reset_index", dataWordIndex, 8'h00);
        check_output("reset_synclost", syncLost, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("enable_to_hpre", decode_state, 3'b001);

        // Header field after a long preamble.
        send_zeros(40);
        check_output("hpre_hold", decode_state, 3'b001);
        apply_stimulus(1'b1);
        check_output("hdr_enter", snap_state, 3'b010);
        check_output("sync_not_forwarded", hdr_cnt, 0);
        send_header(47);
        check_output("hdr_47_state", decode_state, 3'b010);
        check_output("hdr_47_count", hdr_cnt, 47);
        apply_stimulus(hdr_vec[47]);
        check_output("hdr_to_gap", snap_state, 3'b011);
        check_output("hdr_48_count", hdr_cnt, 48);
        check_output("hdr_last_in_gap", hdr_last_state, 3'b011);
        bad = 0;
        for (int i = 0; i < 48; i++) if (hdr_bits[i] !== hdr_vec[i]) bad++;
        check_output("hdr_bits", bad, 0);

        // Gap, data preamble, 128 data words and the CRC.
        send_zeros(63);
        check_output("gap_63", decode_state, 3'b011);
        apply_stimulus(1'b0);
        check_output("gap_to_dpre", snap_state, 3'b100);
        send_zeros(32);
        apply_stimulus(1'b1);
        check_output("dpre_to_data", snap_state, 3'b101);
        for (int i = 0; i < 15; i++) apply_stimulus(word_val(0)[i]);
        check_output("w0_no_early_strobe", snap_dstrobe, 1'b0);
        apply_stimulus(word_val(0)[15]);
        check_output("w0_strobe", snap_dstrobe, 1'b1);
        check_output("w0_word", snap_word, 16'h1234);
        check_output("w0_index", snap_index, 8'd0);
        check_output("w0_hold", dataWord, 16'h1234);
        for (int w = 1; w < 128; w++) send_word_lsb(word_val(w));
        check_output("data_strobes_128", dstrobe_cnt, 128);
        crc = 16'h0F0F;
        for (int i = 15; i >= 0; i--) apply_stimulus(crc[i]);
        check_output("crc_strobe", snap_dstrobe, 1'b1);
        check_output("crc_index", snap_index, 8'd128);
        check_output("after_crc_hpre", snap_state, 3'b001);
        check_output("word_0", words[0], 16'h1234);
        check_output("word_1", words[1], 16'hA5A5);
        check_output("word_127", words[127], 16'h7F7F);
        check_output("word_crc", words[128], 16'h0F0F);
        check_output("data_strobes_129", dstrobe_cnt, 129);
        check_output("no_synclost_yet", sync_cnt, 0);

        // Short preamble rejected, then a valid one accepted.
        send_zeros(20);
        apply_stimulus(1'b1);
        check_output("short_pre_reject", snap_state, 3'b001);
        send_zeros(40);
        apply_stimulus(1'b1);
        check_output("long_pre_accept", snap_state, 3'b010);

        // Abort mid-header.
        base_h = hdr_cnt;
        send_header(20);
        check_output("abort_hdr_20", hdr_cnt - base_h, 20);
        enable = 1'b0;
        @(posedge clk); #1;
        check_output("abort_idle", decode_state, 3'b000);
        check_output("abort_synclost", syncLost, 1'b1);
        send_header(10);
        check_output("abort_no_more_hdr", hdr_cnt - base_h, 20);
        check_output("abort_synclost_once", sync_cnt, 1);
        check_output("abort_still_idle", decode_state, 3'b000);
        enable = 1'b1;
        @(posedge clk); #1;
        check_output("reenable_hpre", decode_state, 3'b001);

        // Preamble boundary: 31 zeros rejected, 32 accepted.
        send_zeros(31);
        apply_stimulus(1'b1);
        check_output("pre_31_reject", snap_state, 3'b001);
        send_zeros(32);
        apply_stimulus(1'b1);
        check_output("pre_32_accept", snap_state, 3'b010);

        // Data sync timeout.
        send_header(48);
        send_zeros(64);
        check_output("timeout_dpre", decode_state, 3'b100);
        base_d = dstrobe_cnt;
        base_s = sync_cnt;
        send_zeros(255);
        check_output("timeout_255_hold", decode_state, 3'b100);
        check_output("timeout_255_nolost", sync_cnt - base_s, 0);
        apply_stimulus(1'b0);
        check_output("timeout_pulse", snap_sync, 1'b1);
        check_output("timeout_hpre", snap_state, 3'b001);
        check_output("timeout_one_pulse", sync_cnt - base_s, 1);
        check_output("timeout_no_data", dstrobe_cnt - base_d, 0);

        // Reset during data word 50, then reacquire.
        send_zeros(40);
        apply_stimulus(1'b1);
        send_header(48);
        send_zeros(64);
        send_zeros(32);
        apply_stimulus(1'b1);
        check_output("rst_test_data", snap_state, 3'b101);
        base_d = dstrobe_cnt;
        for (int w = 0; w < 50; w++) send_word_lsb(word_val(w));
        check_output("rst_test_50_words", dstrobe_cnt - base_d, 50);
        check_output("rst_test_word49", words[49], word_val(49));
        send_zeros(5);
        base_s = sync_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("midrst_state", decode_state, 3'b000);
        check_output("midrst_hbit", headerBitIn, 1'b0);
        check_output("midrst_hstrobe", headerBitInStrobe, 1'b0);
        check_output("midrst_word", dataWord, 16'h0000);
        check_output("midrst_dstrobe", dataWordStrobe, 1'b0);
        check_output("midrst_index", dataWordIndex, 8'h00);
        check_output("midrst_synclost", syncLost, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("midrst_no_synclost", sync_cnt - base_s, 0);
        check_output("midrst_hpre", decode_state, 3'b001);
        base_h = hdr_cnt;
        send_zeros(40);
        apply_stimulus(1'b1);
        check_output("reacq_hdr", snap_state, 3'b010);
        send_header(48);
        check_output("reacq_hdr_count", hdr_cnt - base_h, 48);
        check_output("reacq_gap", decode_state, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
